// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter: 8 requesters share one resource, grant held until release.
// Optional forced revocation after MAX_GRANT cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
    parameter int NUM_REQ   = 8,
    parameter int IDW       = 3,
    parameter int MAX_GRANT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               valid,
    output logic               timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               valid_q, valid_d;
    logic [IDW-1:0]     winner;

    // First set bit of r scanning upward from p with wrap-around.
    function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [IDW-1:0]     p);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] sel;
        logic           found;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = p + IDW'(i);
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign winner = pick_winner(req, ptr_q);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_GRANT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    valid_d         = 1'b1;
                    cnt_d           = 8'd0;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                // A voluntary release wins over a limit hit on the same cycle.
                if (!req[grant_id_q]) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = grant_id_q + IDW'(1);
                    state_d = IDLE;
                end else if (cnt_q == HOLD_LIMIT) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    ptr_d     = grant_id_q + IDW'(1);
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    grant_id_d      = winner;
                    valid_d         = 1'b1;
                    state_d         = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_id_q]) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = grant_id_q + IDW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            valid_q    <= valid_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign valid    = valid_q;

`ifndef SYNTHESIS
    a_max_grant_range: assert property (@(posedge clk) MAX_GRANT >= 2 && MAX_GRANT <= 255);
    a_grant_onehot0:   assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_valid_matches:   assert property (@(posedge clk) disable iff (rst) valid_q == (|grant_q));
    a_id_matches:      assert property (@(posedge clk) disable iff (rst) !valid_q || grant_q[grant_id_q]);
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: directed scenarios then randomized traffic
// against a behavioural model (MAX_GRANT = 4 so the optional timeout is reachable).
module tb_rr_arbiter_8;

    localparam int MG = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       valid;
    logic       timeout;

    rr_arbiter_8 #(.NUM_REQ(8), .IDW(3), .MAX_GRANT(MG)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .grant_id (grant_id),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Behavioural model state: who holds the resource (-1 = nobody).
    int m_holder = -1;
    int m_ptr    = 0;
    int m_id     = 0;
    int m_cnt    = 0;
    int m_to     = 0;

    function automatic bit timeout_enabled();
`ifdef ARB_TIMEOUT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Winner = requesting index with the smallest circular distance from the pointer.
    function automatic int rr_pick(input logic [7:0] r, input int p);
        int best  = -1;
        int bestd = 99;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
                int d = (i - p + 8) % 8;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_edge(input logic [7:0] r, input logic rs);
        m_to = 0;
        if (rs) begin
            m_holder = -1;
            m_ptr    = 0;
            m_id     = 0;
            m_cnt    = 0;
        end else if (m_holder < 0) begin
            if (r != 8'h00) begin
                m_holder = rr_pick(r, m_ptr);
                m_id     = m_holder;
                m_cnt    = 0;
            end
        end else if (!r[m_holder]) begin
            m_ptr    = (m_holder + 1) % 8;
            m_holder = -1;
        end else if (timeout_enabled() && m_cnt == MG - 1) begin
            m_ptr    = (m_holder + 1) % 8;
            m_holder = -1;
            m_to     = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        rst = rs;
        model_edge(r, rs);
        e.g  = (m_holder >= 0) ? (8'h01 << m_holder) : 8'h00;
        e.id = 3'(m_id);
        e.v  = (m_holder >= 0);
        e.t  = (m_to != 0);
        exp_q.push_back(e);
    endtask

    // Monitor: one expected record per clock, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            bit   bad;
            e   = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if (grant !== e.g) begin
                $display("FAIL grant @%0t: got %b expected %b", $time, grant, e.g);
                bad = 1'b1;
            end
            if (grant_id !== e.id) begin
                $display("FAIL grant_id @%0t: got %0d expected %0d", $time, grant_id, e.id);
                bad = 1'b1;
            end
            if (valid !== e.v) begin
                $display("FAIL valid @%0t: got %b expected %b", $time, valid, e.v);
                bad = 1'b1;
            end
            if (timeout !== e.t) begin
                $display("FAIL timeout @%0t: got %b expected %b", $time, timeout, e.t);
                bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    logic [7:0] rnd_req;

    initial begin
        rst = 1'b1;
        req = 8'h00;

        // Reset with every requester asserted, then idle.
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        repeat (3) step(8'h00, 1'b0);

        // Single request from pointer 0: bit 1 first, then bit 4 after release.
        repeat (6) step(8'h12, 1'b0);
        repeat (4) step(8'h10, 1'b0);
        repeat (2) step(8'h00, 1'b0);

        // Rotation with all bits requesting; holder drops after 3 grant cycles.
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        repeat (45) begin
            logic [7:0] r;
            r = 8'hFF;
            if (m_holder >= 0 && m_cnt >= 2) r[m_holder] = 1'b0;
            step(r, 1'b0);
        end
        repeat (2) step(8'h00, 1'b0);

        // Wrap-around: release on 6 leaves pointer at 7.
        step(8'h00, 1'b1);
        repeat (3) step(8'h40, 1'b0);
        step(8'h00, 1'b0);
        repeat (3) step(8'h81, 1'b0);
        repeat (3) step(8'h01, 1'b0);
        step(8'h00, 1'b0);

        // No preemption, then reset in the middle of a grant.
        step(8'h00, 1'b1);
        repeat (2) step(8'h08, 1'b0);
        repeat (3) step(8'h09, 1'b0);
        step(8'h09, 1'b1);
        repeat (3) step(8'h09, 1'b0);
        repeat (2) step(8'h00, 1'b0);

        // Long hold on 0 with 2 waiting: revoked only with the timeout feature.
        step(8'h00, 1'b1);
        repeat (24) step(8'h05, 1'b0);
        repeat (2) step(8'h00, 1'b0);

        // Randomized traffic: bits toggle sparsely, occasional reset.
        rnd_req = 8'h00;
        repeat (3000) begin
            rnd_req = rnd_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step(rnd_req, ($urandom_range(0, 199) == 0));
        end
        repeat (2) step(8'h00, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            miscompares++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
